// File: rtl/data_mem_responder.sv
// CPU data-memory responder: word RAM plus MMIO page (OUT_REG, CYCLE, TX FIFO, STATUS).
// Loads are zero-latency combinational; the TX stream holds its head while tx_ready is low and drops stores to a full FIFO.
module data_mem_responder #(
    parameter int          RAM_WORDS  = 64,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [31:0] IO_BASE    = 32'h0000_1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] ALUResult,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic [31:0] out_port,
    output logic        tx_valid,
    output logic [31:0] tx_data,
    input  logic        tx_ready
);

    localparam int          AW        = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
    localparam int          PW        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int          CW        = $clog2(FIFO_DEPTH + 1);
    localparam logic [31:0] RAM_BYTES = 32'(RAM_WORDS * 4);

    localparam logic [1:0] OFS_OUT    = 2'd0;
    localparam logic [1:0] OFS_CYCLE  = 2'd1;
    localparam logic [1:0] OFS_TXDATA = 2'd2;
    localparam logic [1:0] OFS_STATUS = 2'd3;

    logic [31:0]   r_ram [RAM_WORDS];
    logic [31:0]   r_fifo [FIFO_DEPTH];
    logic [31:0]   r_out;
    logic [31:0]   r_cycle;
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;
    logic          r_ovf;
    logic          r_badaddr;

    logic          w_ram_hit;
    logic          w_io_hit;
    logic [1:0]    w_io_ofs;
    logic [AW-1:0] w_ram_idx;
    logic          w_empty;
    logic          w_full;
    logic          w_pop;
    logic          w_push_req;
    logic          w_push_ok;
    logic          w_push_drop;
    logic          w_out_wr;
    logic          w_cyc_wr;
    logic          w_stat_wr;
    logic          w_bad_wr;
    logic [31:0]   w_status;
    logic          w_unused;

    // Word access only: the byte-lane bits carry no meaning here.
    assign w_unused  = ^ALUResult[1:0];

    assign w_ram_hit = (ALUResult < RAM_BYTES);
    assign w_io_hit  = !w_ram_hit && (ALUResult[31:4] == IO_BASE[31:4]);
    assign w_io_ofs  = ALUResult[3:2];
    assign w_ram_idx = ALUResult[AW+1:2];

    assign w_empty     = (r_count == '0);
    assign w_full      = (r_count == CW'(FIFO_DEPTH));
    assign w_pop       = tx_valid && tx_ready;
    assign w_push_req  = MemWrite && w_io_hit && (w_io_ofs == OFS_TXDATA);
    assign w_push_ok   = w_push_req && (!w_full || w_pop);
    assign w_push_drop = w_push_req && w_full && !w_pop;

    assign w_out_wr  = MemWrite && w_io_hit && (w_io_ofs == OFS_OUT);
    assign w_cyc_wr  = MemWrite && w_io_hit && (w_io_ofs == OFS_CYCLE);
    assign w_stat_wr = MemWrite && w_io_hit && (w_io_ofs == OFS_STATUS);
    assign w_bad_wr  = MemWrite && !w_ram_hit && !w_io_hit;

    assign w_status = {r_badaddr, r_ovf, 22'd0, 4'(r_count), 2'd0, w_full, w_empty};

    assign out_port = r_out;
    assign tx_valid = !w_empty;
    assign tx_data  = tx_valid ? r_fifo[r_rd_ptr] : 32'd0;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        ReadData = 32'd0;
        if (w_ram_hit) begin
            ReadData = r_ram[w_ram_idx];
        end else if (w_io_hit) begin
            case (w_io_ofs)
                OFS_OUT:    ReadData = r_out;
                OFS_CYCLE:  ReadData = r_cycle;
                OFS_STATUS: ReadData = w_status;
                default:    ReadData = 32'd0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (MemWrite && w_ram_hit) begin
            r_ram[w_ram_idx] <= WriteData;
        end
    end

    // When full, a simultaneous pop frees the head slot that wr_ptr points at.
    always_ff @(posedge clk) begin
        if (reset && w_push_ok) begin
            r_fifo[r_wr_ptr] <= WriteData;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_out     <= 32'd0;
            r_cycle   <= 32'd0;
            r_rd_ptr  <= '0;
            r_wr_ptr  <= '0;
            r_count   <= '0;
            r_ovf     <= 1'b0;
            r_badaddr <= 1'b0;
        end else begin
            r_cycle <= w_cyc_wr ? WriteData : r_cycle + 32'd1;

            if (w_out_wr) begin
                r_out <= WriteData;
            end

            if (w_stat_wr) begin
                r_ovf     <= 1'b0;
                r_badaddr <= 1'b0;
            end else begin
                if (w_push_drop) r_ovf     <= 1'b1;
                if (w_bad_wr)    r_badaddr <= 1'b1;
            end

            if (w_push_ok) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (w_pop)     r_rd_ptr <= ptr_inc(r_rd_ptr);

            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
